// File: rtl/dmem_arbiter_ctrl.sv
// Two-port arbiter and read-latency sequencer for the single-port data memory.
// Define DMEM_PERFCNT_EN to build the port 0 stall-cycle counter on perf_p0_stall.
module dmem_arbiter_ctrl #(
  parameter int DBITS      = 32,
  parameter int AWIDTH     = 14,
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [DBITS-1:0]  p0_addr,
  input  logic [DBITS-1:0]  p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DBITS-1:0]  p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [DBITS-1:0]  p1_addr,
  input  logic [DBITS-1:0]  p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DBITS-1:0]  p1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DBITS-1:0]  mem_wdata,
  input  logic [DBITS-1:0]  mem_rdata,
  output logic              busy,
  output logic [31:0]       perf_p0_stall
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_e;

  state_e             state_q;
  logic [2:0]         cnt_q;
  logic               owner_q;
  logic [3:0]         starve_q, starve_d;
  logic               p0_rvalid_q, p1_rvalid_q;
  logic [DBITS-1:0]   p0_rdata_q, p1_rdata_q;
  logic               idle, starved, rd_gnt;
  logic               unused_addr;

  // Grants are gated by reset so nothing reaches the memory while reset is held.
  assign idle    = reset && (state_q == ST_IDLE);
  assign starved = (starve_q == 4'(STARVE_MAX));
  assign p1_gnt  = idle && p1_req && (!p0_req || starved);
  assign p0_gnt  = idle && p0_req && !p1_gnt;
  assign rd_gnt  = (p0_gnt && !p0_we) || (p1_gnt && !p1_we);

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (p0_gnt) begin
      mem_en    = 1'b1;
      mem_we    = p0_we;
      mem_addr  = p0_addr[AWIDTH+1:2];
      mem_wdata = p0_wdata;
    end else if (p1_gnt) begin
      mem_en    = 1'b1;
      mem_we    = p1_we;
      mem_addr  = p1_addr[AWIDTH+1:2];
      mem_wdata = p1_wdata;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (idle) begin
      if (!p1_req || p1_gnt) starve_d = '0;
      else if (!starved)     starve_d = starve_q + 4'd1;
    end
  end

  // cnt_q holds the WAIT cycles still to go; the last one captures mem_rdata.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      owner_q     <= 1'b0;
      starve_q    <= '0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
    end else begin
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      starve_q    <= starve_d;
      case (state_q)
        ST_IDLE: begin
          if (rd_gnt) begin
            if (RD_LAT == 1) begin
              if (p1_gnt) begin
                p1_rvalid_q <= 1'b1;
                p1_rdata_q  <= mem_rdata;
              end else begin
                p0_rvalid_q <= 1'b1;
                p0_rdata_q  <= mem_rdata;
              end
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= 3'(RD_LAT - 1);
              owner_q <= p1_gnt;
            end
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_q <= ST_IDLE;
            if (owner_q) begin
              p1_rvalid_q <= 1'b1;
              p1_rdata_q  <= mem_rdata;
            end else begin
              p0_rvalid_q <= 1'b1;
              p0_rdata_q  <= mem_rdata;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign p0_rvalid = p0_rvalid_q;
  assign p1_rvalid = p1_rvalid_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;
  assign busy      = (state_q == ST_WAIT);

`ifdef DMEM_PERFCNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 perf_q <= '0;
    else if (p0_req && !p0_gnt) perf_q <= perf_q + 32'd1;
  end

  assign perf_p0_stall = perf_q;
`else
  assign perf_p0_stall = '0;
`endif

  assign unused_addr = ^{p0_addr[DBITS-1:AWIDTH+2], p0_addr[1:0],
                         p1_addr[DBITS-1:AWIDTH+2], p1_addr[1:0]};

endmodule

// File: tb/tb_dmem_arbiter_ctrl.sv
// Bench for dmem_arbiter_ctrl: directed traffic, a transaction-level reference
// model compared every cycle, and hand-computed spot checks.
module tb_dmem_arbiter_ctrl;

  localparam int DBITS      = 32;
  localparam int AWIDTH     = 14;
  localparam int RD_LAT     = 2;
  localparam int STARVE_MAX = 4;

  logic              clk;
  logic              reset;
  logic              p0_req, p0_we, p1_req, p1_we;
  logic [DBITS-1:0]  p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic              p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [DBITS-1:0]  p0_rdata, p1_rdata;
  logic              mem_en, mem_we, busy;
  logic [AWIDTH-1:0] mem_addr;
  logic [DBITS-1:0]  mem_wdata, mem_rdata;
  logic [31:0]       perf_p0_stall;

  int nChecks = 0;
  int nFails  = 0;

  dmem_arbiter_ctrl #(
    .DBITS(DBITS), .AWIDTH(AWIDTH), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .perf_p0_stall(perf_p0_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical memory: one output register, so read data sits ready for the capture edge.
  logic [DBITS-1:0] phys [0:(1<<AWIDTH)-1];
  initial begin
    for (int i = 0; i < (1 << AWIDTH); i++) phys[i] = '0;
    mem_rdata = '0;
  end
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) phys[mem_addr] <= mem_wdata;
      else        mem_rdata      <= phys[mem_addr];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // Reference model: transaction level, in absolute cycle numbers.
  logic [DBITS-1:0] refMem [0:(1<<AWIDTH)-1];
  initial for (int i = 0; i < (1 << AWIDTH); i++) refMem[i] = '0;

  longint     cyc = 0;
  longint     freeAt = 0;
  longint     pendDue = 0;
  bit         pendValid = 0;
  int         pendOwner = 0;
  logic [31:0] pendData = '0;
  logic [31:0] mRd [2];
  bit         mRv [2];
  int         starve = 0;
  logic [31:0] perfExp = '0;
  int         win;
  bit         idle;
  logic [31:0] wAddr, wData;
  bit         wWe;

  initial begin
    mRd[0] = '0; mRd[1] = '0;
  end

  always @(negedge clk) begin
    if (!reset) begin
      pendValid = 0; freeAt = 0; starve = 0; perfExp = '0;
      mRd[0] = '0; mRd[1] = '0;
      checkOutput("rst_p0_gnt",    32'(p0_gnt),    32'd0);
      checkOutput("rst_p1_gnt",    32'(p1_gnt),    32'd0);
      checkOutput("rst_mem_en",    32'(mem_en),    32'd0);
      checkOutput("rst_p0_rvalid", 32'(p0_rvalid), 32'd0);
      checkOutput("rst_p1_rvalid", 32'(p1_rvalid), 32'd0);
      checkOutput("rst_p0_rdata",  p0_rdata,       32'd0);
      checkOutput("rst_p1_rdata",  p1_rdata,       32'd0);
      checkOutput("rst_busy",      32'(busy),      32'd0);
      checkOutput("rst_perf",      perf_p0_stall,  32'd0);
    end else begin
      mRv[0] = 0; mRv[1] = 0;
      if (pendValid && pendDue == cyc) begin
        mRv[pendOwner] = 1;
        mRd[pendOwner] = pendData;
        pendValid = 0;
      end
      idle = (cyc >= freeAt);
      win = -1;
      if (idle) begin
        if (p1_req && (!p0_req || starve == STARVE_MAX)) win = 1;
        else if (p0_req)                                 win = 0;
      end
      wAddr = (win == 1) ? p1_addr  : p0_addr;
      wData = (win == 1) ? p1_wdata : p0_wdata;
      wWe   = (win == 1) ? p1_we    : p0_we;

      checkOutput("p0_gnt",    32'(p0_gnt),    32'(win == 0));
      checkOutput("p1_gnt",    32'(p1_gnt),    32'(win == 1));
      checkOutput("mem_en",    32'(mem_en),    32'(win >= 0));
      if (win >= 0) begin
        checkOutput("mem_we",    32'(mem_we),   32'(wWe));
        checkOutput("mem_addr",  32'(mem_addr), 32'(wAddr[AWIDTH+1:2]));
        if (wWe) checkOutput("mem_wdata", mem_wdata, wData);
      end
      checkOutput("p0_rvalid", 32'(p0_rvalid), 32'(mRv[0]));
      checkOutput("p1_rvalid", 32'(p1_rvalid), 32'(mRv[1]));
      checkOutput("p0_rdata",  p0_rdata,       mRd[0]);
      checkOutput("p1_rdata",  p1_rdata,       mRd[1]);
      checkOutput("busy",      32'(busy),      32'(!idle));
      checkOutput("perf",      perf_p0_stall,  perfExp);

      if (win >= 0) begin
        if (wWe) refMem[wAddr[AWIDTH+1:2]] = wData;
        else begin
          pendValid = 1;
          pendDue   = cyc + RD_LAT;
          pendOwner = win;
          pendData  = refMem[wAddr[AWIDTH+1:2]];
          freeAt    = cyc + RD_LAT;
        end
      end
      if (idle) begin
        if (!p1_req || win == 1)       starve = 0;
        else if (starve < STARVE_MAX)  starve++;
      end
`ifdef DMEM_PERFCNT_EN
      if (p0_req && win != 0) perfExp = perfExp + 32'd1;
`endif
    end
    cyc++;
  end

  task automatic cyc1();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic applyStimulus(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                               input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
  endtask

  initial begin
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) cyc1();
    settle();
    checkOutput("lit_rst_busy",   32'(busy), 32'd0);
    checkOutput("lit_rst_rdata0", p0_rdata,  32'd0);
    cyc1();
    reset = 1'b1;

    // Loader writes the image word, then port 0 reads it back.
    cyc1(); applyStimulus(0, 0, 0, 0, 1, 1, 32'h10, 32'hDEADBEEF); settle();
    checkOutput("lit_load_gnt",  32'(p1_gnt),   32'd1);
    checkOutput("lit_load_addr", 32'(mem_addr), 32'd4);
    cyc1(); applyStimulus(1, 0, 32'h10, 0, 0, 0, 0, 0); settle();
    checkOutput("lit_rd_gnt",  32'(p0_gnt),   32'd1);
    checkOutput("lit_rd_addr", 32'(mem_addr), 32'd4);
    checkOutput("lit_rd_we",   32'(mem_we),   32'd0);
    cyc1(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0); settle();
    checkOutput("lit_rd_busy",   32'(busy),      32'd1);
    checkOutput("lit_rd_early",  32'(p0_rvalid), 32'd0);
    cyc1(); settle();
    checkOutput("lit_rd_valid",  32'(p0_rvalid), 32'd1);
    checkOutput("lit_rd_data",   p0_rdata,       32'hDEADBEEF);
    cyc1(); settle();
    checkOutput("lit_rd_pulse",  32'(p0_rvalid), 32'd0);
    checkOutput("lit_rd_hold",   p0_rdata,       32'hDEADBEEF);

    // Write then read back-to-back; upper address bits must wrap away.
    cyc1(); applyStimulus(1, 1, 32'hFFFF0020, 32'h12345678, 0, 0, 0, 0); settle();
    checkOutput("lit_wr_gnt",  32'(p0_gnt),   32'd1);
    checkOutput("lit_wr_addr", 32'(mem_addr), 32'd8);
    cyc1(); applyStimulus(1, 0, 32'h20, 0, 0, 0, 0, 0); settle();
    checkOutput("lit_wr_rd_gnt", 32'(p0_gnt), 32'd1);
    cyc1(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0); settle();
    cyc1(); settle();
    checkOutput("lit_wr_rd_data", p0_rdata, 32'h12345678);

    // Both ports writing continuously: port 1 wins every fifth cycle.
    for (int k = 0; k < 15; k++) begin
      cyc1();
      applyStimulus(1, 1, 32'h400 + 32'(4 * k), 32'(k),
                    1, 1, 32'h800 + 32'(4 * (k / 5)), 32'h100 + 32'(k / 5));
      settle();
      checkOutput("lit_starve_p1", 32'(p1_gnt), 32'((k % 5) == 4));
      checkOutput("lit_starve_p0", 32'(p0_gnt), 32'((k % 5) != 4));
    end
    cyc1(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    // Port 1 read in flight blocks port 0 until the return cycle.
    cyc1(); applyStimulus(0, 0, 0, 0, 1, 0, 32'h10, 0); settle();
    checkOutput("lit_p1rd_gnt", 32'(p1_gnt), 32'd1);
    cyc1(); applyStimulus(1, 0, 32'h20, 0, 0, 0, 0, 0); settle();
    checkOutput("lit_blocked_gnt", 32'(p0_gnt), 32'd0);
    cyc1(); settle();
    checkOutput("lit_p1rd_valid", 32'(p1_rvalid), 32'd1);
    checkOutput("lit_p1rd_data",  p1_rdata,       32'hDEADBEEF);
    checkOutput("lit_overlap_gnt", 32'(p0_gnt),   32'd1);
    cyc1(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0); settle();
    cyc1(); settle();
    checkOutput("lit_p0rd_data", p0_rdata, 32'h12345678);

    // Reset during WAIT cancels the read.
    cyc1(); applyStimulus(1, 0, 32'h10, 0, 0, 0, 0, 0); settle();
    checkOutput("lit_cancel_gnt", 32'(p0_gnt), 32'd1);
    cyc1(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0); reset = 1'b0; settle();
    checkOutput("lit_cancel_rdata0", p0_rdata, 32'd0);
    checkOutput("lit_cancel_rdata1", p1_rdata, 32'd0);
    cyc1(); settle();
    checkOutput("lit_cancel_rv", 32'(p0_rvalid), 32'd0);
    cyc1(); reset = 1'b1; settle();
    checkOutput("lit_cancel_rv2",  32'(p0_rvalid), 32'd0);
    checkOutput("lit_cancel_busy", 32'(busy),      32'd0);
    cyc1(); applyStimulus(0, 0, 0, 0, 1, 0, 32'h20, 0); settle();
    checkOutput("lit_after_rst_gnt", 32'(p1_gnt), 32'd1);
    cyc1(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    cyc1(); settle();
    checkOutput("lit_after_rst_data", p1_rdata, 32'h12345678);

    repeat (3) cyc1();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
